imm_gen_pipe: RTL
=================

Name: imm_gen_pipe

Overview:
- Parametrised, pipelined immediate generator for the decode stage. Accepts a 32-bit instruction over a valid/ready handshake.
- Produces the XLEN-wide sign/zero-extended immediate, an immediate-format code, and an illegal-opcode flag, one cycle later.
- A 2-entry skid buffer decouples the fetch and execute stages, so back-pressure never drops or duplicates an instruction.
- Supports RV32 and RV64 through XLEN, and adds JALR, FENCE, SYSTEM/CSR-zimm and the RV64 W-opcodes.

Parameters:
- XLEN, 32, datapath width; only 32 and 64 are legal, any other value is an elaboration error.
- PASS_INSTR, 1, when 1 the instruction is registered alongside the immediate and driven on out_instr; when 0 out_instr is tied to 0.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_instr is valid.
- in_ready  output  1  block can accept an instruction this cycle.
- in_instr  input  32  raw instruction.
- out_valid  output  1  output bundle is valid.
- out_ready  input  1  consumer accepts the output bundle.
- out_imm  output  XLEN  generated immediate.
- out_type  output  3  format code: 0 R, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z (CSR zimm), 7 X (illegal).
- out_illegal  output  1  opcode not recognised.
- out_instr  output  32  registered copy of the instruction.

Behaviour:
- Reset values, applied asynchronously: out_valid=0, skid valid=0, in_ready=1, out_imm=0, out_type=0, out_illegal=0, out_instr=0.
- Transfers: an input transfer happens when in_valid&&in_ready; an output transfer happens when out_valid&&out_ready.
- Latency: an input accepted in cycle N appears on the outputs in cycle N+1 when the output stage is empty or draining.
- Throughput: one instruction per cycle while out_ready=1.
- Decode: combinational on in_instr; its result is written into the output register or the skid register.
- Storage: main output register (M) plus one skid entry (K). in_ready is a registered signal equal to !K.valid, with no combinational path from out_ready.
- State space:
  - EMPTY (M and K invalid).
  - ONE (M valid).
  - FULL (M and K valid).
- Transitions:
  - EMPTY: an input transfer loads M and moves to ONE.
  - ONE, output transfer and no input: go to EMPTY.
  - ONE, output transfer and input: M is reloaded and the state stays ONE.
  - ONE, no output transfer and input: the input goes to K and the state moves to FULL; in_ready=0 next cycle.
  - FULL, output transfer: K moves to M and the state goes to ONE; in_ready=1 next cycle.
  - FULL, no output transfer: hold; inputs are not accepted.
- Ordering: output order always equals input order.
- Hold rule: while out_valid=1 and out_ready=0, every output stays bit-stable.
- Immediate formation (sign extension always to XLEN from instr[31], except U and Z):
  - 0110011 and 0111011 (R, OP-32): imm 0, type R.
  - 0000011, 0010011, 0011011, 1100111, 0001111: imm = instr[31:20], type I.
  - 1110011 with funct3[2]=0: type I.
  - 1110011 with funct3[2]=1: imm = zero-extended instr[19:15], type Z.
  - 0100011: imm = {instr[31:25], instr[11:7]}, type S.
  - 1100011: imm = {instr[31], instr[7], instr[30:25], instr[11:8], 0}, type B.
  - 0110111 and 0010111: imm = {instr[31:12], 12'b0} sign-extended from bit 31, type U.
  - 1101111: imm = {instr[31], instr[19:12], instr[20], instr[30:21], 0}, type J.
- Illegal cases: out_imm=0, out_type=7, out_illegal=1 for:
  - any unlisted opcode;
  - instr[1:0]!=2'b11;
  - opcode 0011011 or 0111011 when XLEN=32.
- Reset mid-operation: M and K are invalidated immediately and held data is discarded. The first post-reset transfer is accepted in the first cycle after reset deasserts.
- Boundary conditions:
  - in_valid with in_ready=0 is ignored; the producer must hold its data.
  - A simultaneous input and output transfer in ONE loses nothing.

Optional Feature:
- Macro: IMM_GEN_ILLEGAL_CNT_EN.
- With the macro defined:
  - Adds output port illegal_cnt [15:0] and input port cnt_clear [0:0].
  - The counter increments once per output transfer that has out_illegal=1, and saturates at 16'hFFFF.
  - cnt_clear=1 zeroes the counter on the next edge, with priority over an increment.
  - Reset value is 0.
- Without the macro: neither port nor the counter exists, and there is no logic overhead.

Test Plan:
- Reset, then in_instr=0xFFF00093 (addi x1,x0,-1), out_ready=1 -> next cycle out_valid=1, out_imm=0xFFFFFFFF (XLEN=32) or 0xFFFFFFFFFFFFFFFF (XLEN=64), out_type=1.
- in_instr=0xFE112E23 (sw x1,-4(x2)) -> out_imm=0xFFFFFFFC, out_type=2; in_instr=0x123452B7 (lui) -> out_imm=0x12345000, type 4; with XLEN=64, 0x800002B7 -> 0xFFFFFFFF80000000.
- Back-pressure: hold out_ready=0 and stream A, B, C back-to-back.
  - A is held in M and B in K; in_ready drops to 0 and C is stalled.
  - Raise out_ready: outputs appear as A, B, C in order, each bit-stable while stalled, with no duplicates.
- Illegal handling:
  - in_instr=0x0000007F -> out_illegal=1, type 7, imm 0.
  - 0x0000001B (addiw) -> illegal only when XLEN=32.
  - With IMM_GEN_ILLEGAL_CNT_EN, 3 illegal transfers -> illegal_cnt=3, then cnt_clear -> 0.
- CSR immediate: in_instr=0x3401D073 (csrrwi, zimm=3) -> out_imm=0x3, out_type=6.
- Reset mid-operation: in the FULL state, assert reset for 1 cycle -> out_valid=0 and in_ready=1 immediately; the next accepted instruction emerges one cycle after acceptance.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// Pipelined RISC-V immediate generator (RV32/RV64) with a 2-entry skid buffer.
// Optional illegal-instruction counter: define IMM_GEN_ILLEGAL_CNT_EN.
module imm_gen_pipe #(
  parameter int XLEN       = 32,
  parameter int PASS_INSTR = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_type,
  output logic            out_illegal,
`ifdef IMM_GEN_ILLEGAL_CNT_EN
  output logic [31:0]     out_instr,
  input  logic            cnt_clear,
  output logic [15:0]     illegal_cnt
`else
  output logic [31:0]     out_instr
`endif
);

  if (!(XLEN == 32 || XLEN == 64)) begin : g_bad_xlen
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end

  localparam logic [2:0] T_R = 3'd0;
  localparam logic [2:0] T_I = 3'd1;
  localparam logic [2:0] T_S = 3'd2;
  localparam logic [2:0] T_B = 3'd3;
  localparam logic [2:0] T_U = 3'd4;
  localparam logic [2:0] T_J = 3'd5;
  localparam logic [2:0] T_Z = 3'd6;
  localparam logic [2:0] T_X = 3'd7;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      typ;
    logic            illegal;
    logic [31:0]     instr;
  } bundle_t;

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  state_t  state;
  bundle_t dec;
  bundle_t m;
  bundle_t k;
  logic    in_xfer;
  logic    out_xfer;
  logic    rv64;

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;
  assign rv64     = (XLEN == 64);

  // Combinational decode of the incoming instruction into an output bundle.
  always_comb begin
    dec         = '0;
    dec.instr   = (PASS_INSTR != 0) ? in_instr : 32'd0;
    dec.typ     = T_X;
    dec.illegal = 1'b1;
    if (in_instr[1:0] == 2'b11) begin
      case (in_instr[6:0])
        7'b0110011: begin
          dec.typ = T_R; dec.illegal = 1'b0;
        end
        7'b0111011: begin
          if (rv64) begin
            dec.typ = T_R; dec.illegal = 1'b0;
          end else begin
            dec.typ = T_X; dec.illegal = 1'b1;
          end
        end
        7'b0000011, 7'b0010011, 7'b1100111, 7'b0001111: begin
          dec.imm = XLEN'($signed(in_instr[31:20]));
          dec.typ = T_I; dec.illegal = 1'b0;
        end
        7'b0011011: begin
          if (rv64) begin
            dec.imm = XLEN'($signed(in_instr[31:20]));
            dec.typ = T_I; dec.illegal = 1'b0;
          end else begin
            dec.typ = T_X; dec.illegal = 1'b1;
          end
        end
        7'b1110011: begin
          // funct3[2] selects the CSR forms that carry a 5-bit zimm in rs1.
          if (in_instr[14]) begin
            dec.imm = XLEN'(in_instr[19:15]);
            dec.typ = T_Z;
          end else begin
            dec.imm = XLEN'($signed(in_instr[31:20]));
            dec.typ = T_I;
          end
          dec.illegal = 1'b0;
        end
        7'b0100011: begin
          dec.imm = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
          dec.typ = T_S; dec.illegal = 1'b0;
        end
        7'b1100011: begin
          dec.imm = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                   in_instr[11:8], 1'b0}));
          dec.typ = T_B; dec.illegal = 1'b0;
        end
        7'b0110111, 7'b0010111: begin
          dec.imm = XLEN'($signed({in_instr[31:12], 12'b0}));
          dec.typ = T_U; dec.illegal = 1'b0;
        end
        7'b1101111: begin
          dec.imm = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                   in_instr[30:21], 1'b0}));
          dec.typ = T_J; dec.illegal = 1'b0;
        end
        default: begin
          dec.imm = '0; dec.typ = T_X; dec.illegal = 1'b1;
        end
      endcase
    end else begin
      dec.imm = '0; dec.typ = T_X; dec.illegal = 1'b1;
    end
  end

  // Skid-buffer control: M is the output register, K catches one extra entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      m         <= '0;
      k         <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (in_xfer) begin
            m         <= dec;
            out_valid <= 1'b1;
            state     <= ONE;
          end
        end
        ONE: begin
          if (out_xfer && in_xfer) begin
            m <= dec;
          end else if (out_xfer) begin
            out_valid <= 1'b0;
            state     <= EMPTY;
          end else if (in_xfer) begin
            k        <= dec;
            in_ready <= 1'b0;
            state    <= FULL;
          end
        end
        FULL: begin
          if (out_xfer) begin
            m        <= k;
            in_ready <= 1'b1;
            state    <= ONE;
          end
        end
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign out_imm     = m.imm;
  assign out_type    = m.typ;
  assign out_illegal = m.illegal;
  assign out_instr   = m.instr;

`ifdef IMM_GEN_ILLEGAL_CNT_EN
  // Saturating count of illegal bundles handed to the consumer; clear wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      illegal_cnt <= 16'd0;
    end else if (cnt_clear) begin
      illegal_cnt <= 16'd0;
    end else if (out_xfer && m.illegal && (illegal_cnt != 16'hFFFF)) begin
      illegal_cnt <= illegal_cnt + 16'd1;
    end
  end
`endif

endmodule
